// File: rtl/wisc_pkg.sv
// Shared encodings for the MEM-stage access controller: memory-enable codes,
// controller states and a small decode helper.
package wisc_pkg;

    // EX/MEM mem_writeEn encoding
    typedef enum logic [1:0] {
        MEM_NONE = 2'b00,
        MEM_LD   = 2'b01,
        MEM_ST   = 2'b10,
        MEM_RSV  = 2'b11
    } mem_en_e;

    // Access controller states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_e;

    // True for the two codes that start a memory transaction
    function automatic logic is_mem_op(input logic [1:0] en);
        return (en == MEM_LD) || (en == MEM_ST);
    endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Saturating cycle counter that bounds how long an access may sit in WAIT.
// expired_o is high while the count sits at TIMEOUT-1.
module mem_timeout_cnt #(
    parameter int TIMEOUT = 64,
    localparam int CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Clear wins over count; hold at CNT_MAX instead of wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: issues one read/write strobe per EX/MEM
// instruction on a stalling data memory, freezes the pipeline until the
// access completes, holds load data for MEM/WB, flags bad/failed accesses
// and raises a single dump request on halt.
module mem_access_ctrl
    import wisc_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [1:0]        mem_en,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              halt,
    input  logic              advance,
    input  logic              mem_stall,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_err,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              createdump,
    output logic              pipe_stall,
    output logic [DATA_W-1:0] rdata_q,
    output logic              err_q
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] rdata_d;
    logic              err_d;
    logic              dump_done_q, dump_done_d;
    logic              is_ld_q, is_ld_d;

    logic op, bad, ld;
    logic rd_s, wr_s, stall_s, dump_s;
    logic cnt_clr, cnt_en, expired;

    // Instruction decode: an unaligned load/store is treated as bad, never issued
    assign op  = req_valid & is_mem_op(mem_en);
    assign ld  = (mem_en == MEM_LD);
    assign bad = req_valid & ((mem_en == MEM_RSV) | (op & addr[0]));

    mem_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (cnt_clr),
        .en_i      (cnt_en),
        .expired_o (expired)
    );

    // Next-state, capture and strobe logic
    always_comb begin
        state_d     = state_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        dump_done_d = dump_done_q;
        is_ld_d     = is_ld_q;
        rd_s        = 1'b0;
        wr_s        = 1'b0;
        stall_s     = 1'b0;
        dump_s      = 1'b0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bad) begin
                    // Dropped as a no-op; only the sticky flag records it
                    err_d = 1'b1;
                end else if (op) begin
                    stall_s = 1'b1;
                    if (!mem_stall) begin
                        rd_s    = ld;
                        wr_s    = ~ld;
                        is_ld_d = ld;
                        if (mem_err) begin
                            err_d = 1'b1;
                        end
                        if (mem_done) begin
                            if (ld) begin
                                rdata_d = mem_rdata;
                            end
                            state_d = DONE;
                        end else begin
                            cnt_clr = 1'b1;
                            state_d = WAIT;
                        end
                    end
                end
                // Dump only from a quiet IDLE, once per reset
                if (req_valid && halt && !op && !dump_done_q) begin
                    dump_s      = 1'b1;
                    dump_done_d = 1'b1;
                end
            end
            WAIT: begin
                stall_s = 1'b1;
                cnt_en  = 1'b1;
                // Completion takes priority over both abort causes
                if (mem_done) begin
                    if (is_ld_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = DONE;
                end else if (mem_err || expired) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Park here until MEM/WB takes the result so nothing re-issues
                if (advance) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller state and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            dump_done_q <= 1'b0;
            is_ld_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            dump_done_q <= dump_done_d;
            is_ld_q     <= is_ld_d;
        end
    end

    // Combinational outputs are forced low while reset is held
    assign mem_rd     = rst & rd_s;
    assign mem_wr     = rst & wr_s;
    assign pipe_stall = rst & stall_s;
    assign createdump = rst & dump_s;
    assign mem_addr   = addr;
    assign mem_wdata  = wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a driver plays both the pipeline and the data
// memory, predicts each instruction's outcome from the access rules and
// queues it; a monitor checks strobes and each stall window against the queue.
module tb_mem_access_ctrl;

    localparam int DW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid, halt, advance, mem_stall, mem_done, mem_err;
    logic [1:0]    mem_en;
    logic [DW-1:0] addr, wdata, mem_rdata;
    logic          mem_rd, mem_wr, createdump, pipe_stall, err_q;
    logic [DW-1:0] mem_addr, mem_wdata, rdata_q;

    always #5 clk = ~clk;

    mem_access_ctrl #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .mem_en(mem_en),
        .addr(addr), .wdata(wdata), .halt(halt), .advance(advance),
        .mem_stall(mem_stall), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .mem_err(mem_err), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .createdump(createdump),
        .pipe_stall(pipe_stall), .rdata_q(rdata_q), .err_q(err_q)
    );

    typedef struct {
        bit            bad;
        bit            wr;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        bit            err;
        int            len;   // cycles pipe_stall stays high
        int            spos;  // stall cycle (1-based) carrying the strobe
    } exp_t;

    exp_t          sbq[$];
    int            n_chk = 0, n_fail = 0;
    logic [DW-1:0] m_rdata = '0;
    bit            m_err = 1'b0;
    bit            mon_en = 1'b1;
    int            bad_mark = 0, bad_seen = 0, dump_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: DUT activity with no expected transaction", nm);
    endtask

    // Monitor: checks strobes as they appear and scores each stall window when it closes
    int   run_len = 0, run_str = 0;
    bit   prev_st = 1'b0;
    exp_t me;
    always @(negedge clk) begin
        if (createdump === 1'b1) dump_cnt++;
        if (!mon_en || !rst) begin
            prev_st = 1'b0;
        end else begin
            if (pipe_stall) begin
                if (!prev_st) begin
                    run_len = 0;
                    run_str = 0;
                end
                run_len++;
                if (mem_rd || mem_wr) begin
                    run_str++;
                    if (sbq.size() == 0) flag("strobe_unexpected");
                    else begin
                        chk("strobe_dir", {mem_wr, mem_rd}, sbq[0].wr ? 2 : 1);
                        chk("strobe_addr", mem_addr, sbq[0].addr);
                        chk("strobe_wdata", mem_wdata, sbq[0].wdata);
                        chk("strobe_pos", run_len, sbq[0].spos);
                    end
                end
            end else begin
                if (mem_rd || mem_wr) chk("strobe_no_stall", {mem_wr, mem_rd}, 0);
                if (prev_st) begin
                    if (sbq.size() == 0) flag("stall_unexpected");
                    else begin
                        me = sbq.pop_front();
                        chk("run_is_mem_op", me.bad, 0);
                        chk("stall_len", run_len, me.len);
                        chk("strobe_cnt", run_str, 1);
                        chk("rdata_q", rdata_q, me.rdata);
                        chk("err_q", err_q, me.err);
                    end
                end
            end
            prev_st = pipe_stall;
            if (bad_mark != bad_seen) begin
                bad_seen++;
                if (sbq.size() == 0) flag("bad_unexpected");
                else begin
                    me = sbq.pop_front();
                    chk("bad_kind", me.bad, 1);
                    chk("bad_err_q", err_q, 1);
                    chk("bad_no_stall", pipe_stall, 0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && sbq.size() != 0; i++) step();
        if (sbq.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d transactions never completed, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        m_rdata = '0;
        m_err   = 1'b0;
    endtask

    // One instruction: stall_n busy cycles, then done/abort relative to the strobe cycle
    task automatic run_op(input logic [1:0] en, input logic [DW-1:0] a, input logic [DW-1:0] wd,
                          input int stall_n, input int done_d, input int abort_at,
                          input logic [DW-1:0] rd, input bit err_iss, input int adv_d);
        bit   ld, st, op, bad, ok;
        int   end_c;
        exp_t e;
        ld  = (en == 2'b01);
        st  = (en == 2'b10);
        op  = ld | st;
        bad = (en == 2'b11) || (op && a[0]);
        req_valid = 1'b1; mem_en = en; addr = a; wdata = wd;
        mem_done = 1'b0; mem_err = 1'b0; advance = 1'b0; mem_rdata = DW'($urandom);
        if (bad) begin
            m_err = 1'b1;
            e = '{bad: 1'b1, wr: 1'b0, addr: a, wdata: wd, rdata: m_rdata, err: 1'b1, len: 0, spos: 0};
            sbq.push_back(e);
            mem_stall = 1'($urandom);
            step();
            req_valid = 1'b0;
            bad_mark++;
        end else if (!op) begin
            mem_stall = 1'($urandom);
            step();
            req_valid = 1'b0;
        end else begin
            // Outcome: whichever of done / mem_err / timeout comes first after the strobe
            end_c = done_d;
            ok    = 1'b1;
            if (abort_at > 0 && abort_at < end_c) begin
                end_c = abort_at;
                ok    = 1'b0;
            end
            if (end_c > TO) begin
                end_c = TO;
                ok    = 1'b0;
            end
            if (err_iss || !ok) m_err = 1'b1;
            if (ld && ok) m_rdata = rd;
            e = '{bad: 1'b0, wr: st, addr: a, wdata: wd, rdata: m_rdata, err: m_err,
                  len: stall_n + end_c + 1, spos: stall_n + 1};
            sbq.push_back(e);
            for (int i = 0; i < stall_n; i++) begin
                mem_stall = 1'b1;
                step();
            end
            mem_stall = 1'b0;
            mem_err   = err_iss;
            mem_done  = (done_d == 0);
            mem_rdata = (done_d == 0) ? rd : DW'($urandom);
            step();
            mem_err = 1'b0;
            for (int c = 1; c <= end_c; c++) begin
                mem_stall = 1'($urandom);
                mem_done  = (c == done_d);
                mem_err   = (c == abort_at);
                mem_rdata = (c == done_d) ? rd : DW'($urandom);
                step();
            end
            mem_done = 1'b0;
            mem_err  = 1'b0;
            for (int i = 0; i < adv_d; i++) begin
                mem_stall = 1'($urandom);
                step();
            end
            advance = 1'b1;
            step();
            advance   = 1'b0;
            req_valid = 1'b0;
            mem_stall = 1'b0;
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected to have ended", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        logic [1:0]    r_en;
        logic [DW-1:0] r_a;
        int            r;
        // Reset values with a load already presented: nothing may leak out
        req_valid = 1'b1; mem_en = 2'b01; addr = 16'h0040; wdata = '0; halt = 1'b1;
        advance = 1'b0; mem_stall = 1'b0; mem_done = 1'b0; mem_rdata = '0; mem_err = 1'b0;
        #1 rst = 1'b0;
        #2;
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_pipe_stall", pipe_stall, 0);
        chk("rst_createdump", createdump, 0);
        chk("rst_rdata_q", rdata_q, 0);
        chk("rst_err_q", err_q, 0);
        req_valid = 1'b0; mem_en = 2'b00; halt = 1'b0;
        step();
        rst = 1'b1;
        step();

        // Load, done three cycles after the strobe
        run_op(2'b01, 16'h0040, 16'h0000, 0, 3, 0, 16'hBEEF, 1'b0, 0);
        chk("t1_rdata", rdata_q, 16'hBEEF);
        // Store completed on the issue cycle
        run_op(2'b10, 16'h0010, 16'h1234, 0, 0, 0, 16'h5555, 1'b0, 1);
        chk("t2_rdata_kept", rdata_q, 16'hBEEF);
        chk("t2_err", err_q, 0);
        // Unaligned load, then reserved code
        run_op(2'b01, 16'h0041, 16'h0000, 0, 1, 0, 16'h7777, 1'b0, 0);
        chk("t3_unaligned_err", err_q, 1);
        do_reset();
        run_op(2'b11, 16'h0044, 16'h0000, 0, 1, 0, 16'h7777, 1'b0, 0);
        chk("t3_reserved_err", err_q, 1);
        do_reset();
        // Busy memory for five cycles, DONE held for two
        run_op(2'b01, 16'h0080, 16'h0000, 5, 2, 0, 16'hA5A5, 1'b0, 2);
        chk("t4_rdata", rdata_q, 16'hA5A5);
        // No completion: abort after TO wait cycles
        run_op(2'b01, 16'h0082, 16'h0000, 0, 100, 0, 16'h1111, 1'b0, 0);
        chk("t5_timeout_err", err_q, 1);
        chk("t5_rdata_kept", rdata_q, 16'hA5A5);
        wait_drain();

        // Reset while waiting on memory clears everything without a clock edge
        mon_en = 1'b0;
        req_valid = 1'b1; mem_en = 2'b01; addr = 16'h0040;
        step();
        step();
        #2 rst = 1'b0;
        #1;
        chk("rstw_pipe_stall", pipe_stall, 0);
        chk("rstw_mem_rd", mem_rd, 0);
        chk("rstw_mem_wr", mem_wr, 0);
        chk("rstw_createdump", createdump, 0);
        chk("rstw_err_q", err_q, 0);
        chk("rstw_rdata_q", rdata_q, 0);
        req_valid = 1'b0; mem_en = 2'b00;
        step();
        rst = 1'b1;
        m_rdata = '0;
        m_err   = 1'b0;
        step();
        mon_en = 1'b1;

        // Halt held four cycles -> one dump; held again -> none until reset
        d0 = dump_cnt;
        req_valid = 1'b1; mem_en = 2'b00; halt = 1'b1;
        repeat (4) step();
        halt = 1'b0; req_valid = 1'b0;
        step();
        chk("dump_once", dump_cnt - d0, 1);
        d0 = dump_cnt;
        req_valid = 1'b1; halt = 1'b1;
        repeat (2) step();
        halt = 1'b0; req_valid = 1'b0;
        step();
        chk("dump_no_repeat", dump_cnt - d0, 0);
        do_reset();
        d0 = dump_cnt;
        req_valid = 1'b1; halt = 1'b1;
        repeat (2) step();
        halt = 1'b0; req_valid = 1'b0;
        step();
        chk("dump_after_reset", dump_cnt - d0, 1);

        // Randomised instruction stream
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            r_en = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 6) ? 2'b01 : 2'b10;
            r_a = DW'($urandom);
            if ($urandom_range(0, 4) != 0) r_a[0] = 1'b0;
            run_op(r_en, r_a, DW'($urandom), $urandom_range(0, 3), $urandom_range(0, 10),
                   ($urandom_range(0, 5) == 0) ? $urandom_range(1, 6) : 0,
                   DW'($urandom), ($urandom_range(0, 15) == 0), $urandom_range(0, 2));
            if ($urandom_range(0, 4) == 0) begin
                wait_drain();
                do_reset();
            end
        end
        wait_drain();
        chk("dump_none_random", createdump, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
